// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared state encoding and op selects for adder_arbiter
package adder_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t ISSUE = 2'd1;
   localparam state_t DONE  = 2'd2;

   localparam logic SEL_ADD = 1'b0;
   localparam logic SEL_SUB = 1'b1;

   function automatic int wrap_inc(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin pick, scanning upward from ptr with wrap
module rr_picker #(
   parameter int N  = 4,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] idx,
   output logic          any_req
);

   // Walk offsets from farthest to nearest so the nearest set bit is written last.
   always_comb begin
      idx     = '0;
      any_req = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         automatic int j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (req[j]) begin
            idx     = j[PW-1:0];
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sharing of one adder/subtractor among N requesters
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic           Clk_in,
   input  logic           Rst_n_in,
   input  logic [N-1:0]   Req_in,
   input  logic [N*W-1:0] A_in,
   input  logic [N*W-1:0] B_in,
   input  logic [N-1:0]   Sel_in,
   output logic [N-1:0]   Grant_out,
   output logic [N-1:0]   Done_out,
   output logic [W:0]     Rez_out,
   output logic           Busy_out,
   output logic [W-1:0]   Add_A_out,
   output logic [W-1:0]   Add_B_out,
   output logic           Add_Sel_out,
   input  logic [W:0]     Add_Rez_in
);

   localparam int PW = $clog2(N);

   state_t        state;
   logic [PW-1:0] ptr;
   logic [PW-1:0] idx;
   logic [PW-1:0] pick;
   logic          any_req;

   rr_picker #(.N(N), .PW(PW)) u_picker (
      .req     (Req_in),
      .ptr     (ptr),
      .idx     (pick),
      .any_req (any_req)
   );

   always_ff @(posedge Clk_in or negedge Rst_n_in) begin
      if (!Rst_n_in) begin
         state       <= IDLE;
         ptr         <= '0;
         idx         <= '0;
         Grant_out   <= '0;
         Done_out    <= '0;
         Rez_out     <= '0;
         Busy_out    <= 1'b0;
         Add_A_out   <= '0;
         Add_B_out   <= '0;
         Add_Sel_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state       <= ISSUE;
                  idx         <= pick;
                  Add_A_out   <= A_in[pick*W +: W];
                  Add_B_out   <= B_in[pick*W +: W];
                  Add_Sel_out <= Sel_in[pick];
                  Grant_out   <= N'(1) << pick;
                  Busy_out    <= 1'b1;
               end
            end
            // Adder inputs have been stable for a full cycle by this edge.
            ISSUE: begin
               state    <= DONE;
               Rez_out  <= Add_Rez_in;
               Done_out <= N'(1) << idx;
            end
            DONE: begin
               state     <= IDLE;
               Done_out  <= '0;
               Grant_out <= '0;
               Busy_out  <= 1'b0;
               ptr       <= PW'(wrap_inc(int'(idx), N));
            end
            default: begin
               state     <= IDLE;
               Done_out  <= '0;
               Grant_out <= '0;
               Busy_out  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - randomized self-checking bench for adder_arbiter with a behavioural adder
module tb_adder_arbiter;
   import adder_arb_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] a_bus;
   logic [31:0] b_bus;
   logic [3:0]  sel;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic [8:0]  rez;
   logic        busy;
   logic [7:0]  add_a;
   logic [7:0]  add_b;
   logic        add_sel;
   logic [8:0]  add_rez;

   int checks;
   int errors;
   int mptr;

   adder_arbiter #(.N(4), .W(8)) dut (
      .Clk_in      (clk),
      .Rst_n_in    (rst_n),
      .Req_in      (req),
      .A_in        (a_bus),
      .B_in        (b_bus),
      .Sel_in      (sel),
      .Grant_out   (grant),
      .Done_out    (done),
      .Rez_out     (rez),
      .Busy_out    (busy),
      .Add_A_out   (add_a),
      .Add_B_out   (add_b),
      .Add_Sel_out (add_sel),
      .Add_Rez_in  (add_rez)
   );

   assign add_rez = (add_sel == SEL_SUB) ? ({1'b0, add_a} - {1'b0, add_b})
                                         : ({1'b0, add_a} + {1'b0, add_b});

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic logic [8:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic s);
      int v;
      v = s ? (int'(a) - int'(b)) : (int'(a) + int'(b));
      return 9'(v);
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; req = '0; a_bus = '0; b_bus = '0; sel = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      mptr = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({grant, done, rez, busy, add_a, add_b, add_sel} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got g=%b d=%b r=%h b=%b a=%h b=%h s=%b exp all zero",
                  grant, done, rez, busy, add_a, add_b, add_sel);
      end
      do_reset();
   endtask

   task automatic test_single();
      req = 4'b0001; a_bus = 32'h0000_0001; b_bus = 32'h0000_00C3; sel = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (grant !== 4'b0001 || busy !== 1'b1 || done !== 4'b0000) begin
         errors++; $display("FAIL single_grant got g=%b b=%b d=%b exp g=0001 b=1 d=0000", grant, busy, done);
      end
      req = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (done !== 4'b0001 || rez !== 9'h0C4) begin
         errors++; $display("FAIL single_done got d=%b r=%h exp d=0001 r=0c4", done, rez);
      end
      @(posedge clk); #1;
      checks++;
      if (grant !== 4'b0000 || done !== 4'b0000 || busy !== 1'b0 || rez !== 9'h0C4 || add_a !== 8'h01) begin
         errors++; $display("FAIL single_idle got g=%b d=%b b=%b r=%h a=%h exp 0000 0000 0 0c4 01",
                            grant, done, busy, rez, add_a);
      end
      mptr = 1;
   endtask

   task automatic test_round_robin();
      int order[5] = '{0, 1, 2, 3, 0};
      do_reset();
      req = 4'b1111; a_bus = $urandom; b_bus = $urandom; sel = 4'($urandom);
      for (int n = 0; n < 5; n++) begin
         automatic int w = order[n];
         automatic logic [8:0] exp_rez = ref_alu(a_bus[w*8 +: 8], b_bus[w*8 +: 8], sel[w]);
         @(posedge clk); #1;
         checks++;
         if (grant !== 4'(1 << w) || done !== 4'b0000) begin
            errors++; $display("FAIL rr_grant op%0d got g=%b d=%b exp g=%b d=0000", n, grant, done, 4'(1 << w));
         end
         @(posedge clk); #1;
         checks++;
         if (done !== 4'(1 << w) || rez !== exp_rez || grant !== 4'(1 << w)) begin
            errors++; $display("FAIL rr_done op%0d got d=%b r=%h exp d=%b r=%h", n, done, rez, 4'(1 << w), exp_rez);
         end
         @(posedge clk); #1;
         checks++;
         if (done !== 4'b0000 || grant !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL rr_idle op%0d got d=%b g=%b b=%b exp 0000 0000 0", n, done, grant, busy);
         end
         mptr = (w + 1) % 4;
      end
   endtask

   task automatic test_alternate();
      int w;
      req = 4'b0101;
      for (int n = 0; n < 4; n++) begin
         w = rr_pick(req, mptr);
         @(posedge clk); #1;
         checks++;
         if (grant !== 4'(1 << w) || (grant & 4'b1010) !== 4'b0000) begin
            errors++; $display("FAIL alt_grant op%0d got %b exp %b", n, grant, 4'(1 << w));
         end
         repeat (2) @(posedge clk);
         #1;
         mptr = (w + 1) % 4;
      end
   endtask

   task automatic test_subtract();
      req = 4'b0010; a_bus = 32'h0000_0500; b_bus = 32'h0000_0700; sel = {2'b00, SEL_SUB, 1'b0};
      @(posedge clk); #1;
      checks++;
      if (grant !== 4'b0010 || add_a !== 8'h05 || add_b !== 8'h07 || add_sel !== SEL_SUB) begin
         errors++; $display("FAIL sub_issue got g=%b a=%h b=%h s=%b exp 0010 05 07 1", grant, add_a, add_b, add_sel);
      end
      req = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (done !== 4'b0010 || rez !== 9'h1FE) begin
         errors++; $display("FAIL sub_done got d=%b r=%h exp d=0010 r=1fe", done, rez);
      end
      @(posedge clk); #1;
      mptr = 2;
   endtask

   task automatic test_reset_mid_op();
      req = 4'b0001; a_bus = 32'h0000_0033; b_bus = 32'h0000_0011; sel = 4'b0000;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({grant, done, rez, busy, add_a, add_b, add_sel} !== '0) begin
         errors++; $display("FAIL midrst_async got g=%b d=%b r=%h b=%b exp all zero", grant, done, rez, busy);
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 4'b0000) begin
         errors++; $display("FAIL midrst_nodone got d=%b exp 0000", done);
      end
      rst_n = 1'b1; req = 4'b0100; mptr = 0;
      @(posedge clk); #1;
      checks++;
      if (grant !== 4'b0100) begin
         errors++; $display("FAIL midrst_regrant got g=%b exp 0100", grant);
      end
      req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      mptr = 3;
   endtask

   task automatic test_operand_hold();
      logic [7:0] b0;
      b0 = 8'($urandom);
      do_reset();
      req = 4'b0001; a_bus = {24'h0, 8'h10}; b_bus = {24'h0, b0}; sel = 4'b0000;
      @(posedge clk); #1;
      a_bus = {24'h0, 8'hFF}; b_bus = $urandom; sel = 4'b1111; req = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (done !== 4'b0001 || rez !== ref_alu(8'h10, b0, SEL_ADD) || add_a !== 8'h10) begin
         errors++; $display("FAIL hold_done got d=%b r=%h a=%h exp d=0001 r=%h a=10",
                            done, rez, add_a, ref_alu(8'h10, b0, SEL_ADD));
      end
      @(posedge clk); #1;
      mptr = 1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         automatic int w;
         automatic logic [8:0] exp_rez;
         automatic logic [8:0] prev_rez = rez;
         req = 4'($urandom_range(0, 15)); a_bus = $urandom; b_bus = $urandom; sel = 4'($urandom);
         w = rr_pick(req, mptr);
         if (w < 0) begin
            @(posedge clk); #1;
            checks++;
            if (grant !== 4'b0000 || busy !== 1'b0 || rez !== prev_rez) begin
               errors++; $display("FAIL rnd_idle it%0d got g=%b b=%b r=%h exp 0000 0 %h", n, grant, busy, rez, prev_rez);
            end
            continue;
         end
         exp_rez = ref_alu(a_bus[w*8 +: 8], b_bus[w*8 +: 8], sel[w]);
         @(posedge clk); #1;
         checks++;
         if (grant !== 4'(1 << w) || add_a !== a_bus[w*8 +: 8] || add_b !== b_bus[w*8 +: 8]) begin
            errors++; $display("FAIL rnd_grant it%0d got g=%b a=%h b=%h exp g=%b", n, grant, add_a, add_b, 4'(1 << w));
         end
         req = 4'($urandom); a_bus = $urandom; b_bus = $urandom; sel = 4'($urandom);
         @(posedge clk); #1;
         checks++;
         if (done !== 4'(1 << w) || rez !== exp_rez) begin
            errors++; $display("FAIL rnd_done it%0d got d=%b r=%h exp d=%b r=%h", n, done, rez, 4'(1 << w), exp_rez);
         end
         @(posedge clk); #1;
         mptr = (w + 1) % 4;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      do_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_alternate();
      test_subtract();
      test_reset_mid_op();
      test_operand_hold();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
